// File: rtl/fib_seq_gen.sv
// Fibonacci-type term generator with programmable seeds and valid/ready output.
// Ports: clk, reset (async, active-low), start/stop pulses, mode (0=restart, 1=stop
// on overflow), seed0/seed1, out_ready -> out_valid, number, index, overflow, busy.
// Optional FIB_TERM_LIMIT_EN: adds term_limit input and done pulse output.
module fib_seq_gen #(
   parameter int WIDTH = 8,
   parameter int IDX_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             stop,
   input  logic             mode,
   input  logic [WIDTH-1:0] seed0,
   input  logic [WIDTH-1:0] seed1,
   input  logic             out_ready,
`ifdef FIB_TERM_LIMIT_EN
   input  logic [IDX_W-1:0] term_limit,
   output logic             done,
`endif
   output logic             out_valid,
   output logic [WIDTH-1:0] number,
   output logic [IDX_W-1:0] index,
   output logic             overflow,
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] number_q;
   logic [WIDTH-1:0] b_q;
   logic             b_ovf_q;
   logic [IDX_W-1:0] index_q;
   logic             valid_q;
   logic             ovf_q;
   logic             busy_q;

   logic [WIDTH:0]   sum_d;
   logic [IDX_W-1:0] index_d;
   logic             accept;
   logic             lim_hit;

   // b_ovf holds the carry of the term after number; it is only acted on
   // when that term would actually be presented.
   assign sum_d   = {1'b0, number_q} + {1'b0, b_q};
   assign index_d = index_q + {{(IDX_W-1){1'b0}}, 1'b1};
   assign accept  = (state_q == RUN) && valid_q && out_ready;

`ifdef FIB_TERM_LIMIT_EN
   logic [IDX_W-1:0] limit_q;
   logic             done_q;

   assign lim_hit = (limit_q != '0) && (index_q == limit_q);
   assign done    = done_q;
`else
   assign lim_hit = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         number_q <= '0;
         b_q      <= '0;
         b_ovf_q  <= 1'b0;
         index_q  <= '0;
         valid_q  <= 1'b0;
         ovf_q    <= 1'b0;
         busy_q   <= 1'b0;
`ifdef FIB_TERM_LIMIT_EN
         limit_q  <= '0;
         done_q   <= 1'b0;
`endif
      end else begin
         ovf_q <= 1'b0;
`ifdef FIB_TERM_LIMIT_EN
         done_q <= 1'b0;
`endif
         if (stop) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
         end else if (start) begin
            state_q  <= RUN;
            number_q <= seed0;
            b_q      <= seed1;
            b_ovf_q  <= 1'b0;
            index_q  <= '0;
            valid_q  <= 1'b1;
            busy_q   <= 1'b1;
`ifdef FIB_TERM_LIMIT_EN
            limit_q  <= term_limit;
`endif
         end else if (accept) begin
            if (lim_hit) begin
               state_q <= DONE;
               valid_q <= 1'b0;
               busy_q  <= 1'b0;
`ifdef FIB_TERM_LIMIT_EN
               done_q  <= 1'b1;
`endif
            end else if (!b_ovf_q) begin
               number_q         <= b_q;
               {b_ovf_q, b_q}   <= sum_d;
               index_q          <= index_d;
            end else if (!mode) begin
               // wrap: restart from freshly sampled seeds
               number_q <= seed0;
               b_q      <= seed1;
               b_ovf_q  <= 1'b0;
               index_q  <= '0;
               ovf_q    <= 1'b1;
`ifdef FIB_TERM_LIMIT_EN
               limit_q  <= term_limit;
`endif
            end else begin
               state_q <= DONE;
               valid_q <= 1'b0;
               busy_q  <= 1'b0;
               ovf_q   <= 1'b1;
            end
         end
      end
   end

   assign out_valid = valid_q;
   assign number    = number_q;
   assign index     = index_q;
   assign overflow  = ovf_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_fib_seq_gen.sv
// Directed bench for fib_seq_gen (WIDTH=8, IDX_W=8).
// Covers reset, wrap, backpressure, stop priority, stop-on-overflow, resample, async reset.
module tb_fib_seq_gen;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       start = 1'b0;
   logic       stop = 1'b0;
   logic       mode = 1'b0;
   logic [7:0] seed0 = 8'd0;
   logic [7:0] seed1 = 8'd1;
   logic       out_ready = 1'b1;
   logic       out_valid;
   logic [7:0] number;
   logic [7:0] index;
   logic       overflow;
   logic       busy;
`ifdef FIB_TERM_LIMIT_EN
   logic [7:0] term_limit = 8'd0;
   logic       done;
`endif

   int total = 0;
   int bad = 0;

   int fib01[14] = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233};
   int fib21[12] = '{2, 1, 3, 4, 7, 11, 18, 29, 47, 76, 123, 199};

   fib_seq_gen #(.WIDTH(8), .IDX_W(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .stop      (stop),
      .mode      (mode),
      .seed0     (seed0),
      .seed1     (seed1),
      .out_ready (out_ready),
`ifdef FIB_TERM_LIMIT_EN
      .term_limit(term_limit),
      .done      (done),
`endif
      .out_valid (out_valid),
      .number    (number),
      .index     (index),
      .overflow  (overflow),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_term(input string tag, input int n, input int i,
                           input logic v, input logic o);
      chk({tag, ".number"}, 32'(number), 32'(n));
      chk({tag, ".index"}, 32'(index), 32'(i));
      chk({tag, ".valid"}, 32'(out_valid), 32'(v));
      chk({tag, ".ovf"}, 32'(overflow), 32'(o));
   endtask

   initial begin
      // reset state
      tick();
      tick();
      chk_term("rst", 0, 0, 1'b0, 1'b0);
      chk("rst.busy", 32'(busy), 32'd0);
      #2 reset = 1'b1;
      tick();
      chk("idle.valid", 32'(out_valid), 32'd0);

      // seeds 0/1, mode 0, full-rate consumer: wraps after 233
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("run.busy", 32'(busy), 32'd1);
      for (int i = 0; i < 14; i++) begin
         chk_term("seq01", fib01[i], i, 1'b1, 1'b0);
         tick();
      end
      chk_term("wrap", 0, 0, 1'b1, 1'b1);
      tick();
      chk_term("wrap1", 1, 1, 1'b1, 1'b0);

      // backpressure while 5 is presented
      repeat (4) tick();
      chk_term("pre_bp", 5, 5, 1'b1, 1'b0);
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_term("hold", 5, 5, 1'b1, 1'b0);
      end
      out_ready = 1'b1;
      tick();
      chk_term("release", 8, 6, 1'b1, 1'b0);

      // stop beats start; number/index hold
      start = 1'b1;
      stop = 1'b1;
      tick();
      start = 1'b0;
      stop = 1'b0;
      chk_term("stop", 8, 6, 1'b0, 1'b0);
      chk("stop.busy", 32'(busy), 32'd0);
      tick();
      chk("stop.idle", 32'(out_valid), 32'd0);

      // mode 1: stop after 233
      mode = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (13) tick();
      chk_term("m1.last", 233, 13, 1'b1, 1'b0);
      tick();
      chk_term("m1.done", 233, 13, 1'b0, 1'b1);
      chk("m1.busy", 32'(busy), 32'd0);
      tick();
      chk("m1.ovf_pulse", 32'(overflow), 32'd0);
      chk("m1.stay", 32'(out_valid), 32'd0);

      // seeds 2/1 started from DONE, mode 0, seeds changed before wrap
      mode = 1'b0;
      seed0 = 8'd2;
      seed1 = 8'd1;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 12; i++) begin
         chk_term("seq21", fib21[i], i, 1'b1, 1'b0);
         if (i == 11) begin
            seed0 = 8'd5;
            seed1 = 8'd6;
         end
         tick();
      end
      chk_term("resamp", 5, 0, 1'b1, 1'b1);
      tick();
      chk_term("resamp1", 6, 1, 1'b1, 1'b0);

      // async reset between edges
      #2 reset = 1'b0;
      #1;
      chk("arst.valid", 32'(out_valid), 32'd0);
      chk("arst.number", 32'(number), 32'd0);
      chk("arst.busy", 32'(busy), 32'd0);
      #2 reset = 1'b1;
      tick();
      tick();
      chk("arst.idle", 32'(out_valid), 32'd0);
      chk("arst.idle_busy", 32'(busy), 32'd0);

`ifdef FIB_TERM_LIMIT_EN
      seed0 = 8'd0;
      seed1 = 8'd1;
      term_limit = 8'd4;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk_term("lim", fib01[i], i, 1'b1, 1'b0);
         tick();
      end
      chk("lim.done", 32'(done), 32'd1);
      chk("lim.valid", 32'(out_valid), 32'd0);
      chk("lim.busy", 32'(busy), 32'd0);
      tick();
      chk("lim.pulse", 32'(done), 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
